// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding, PWM constants and ramp arithmetic for pwm_ctrl.
// Contents: pwm_state_e, PWM_MAX, PERIOD_LAST, default CLK_DIV/RAMP_STEP, ramp_next().
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } pwm_state_e;

    localparam logic [7:0] PWM_MAX     = 8'd255;
    localparam logic [7:0] PERIOD_LAST = 8'd254;
    localparam int DEF_CLK_DIV   = 196;
    localparam int DEF_RAMP_STEP = 8;

    // One ramp step toward target, limited to step. Working at 9 bits keeps the
    // result between duty and target, so it can neither overshoot nor wrap.
    function automatic logic [7:0] ramp_next(input logic [7:0] duty,
                                             input logic [7:0] target,
                                             input logic [7:0] step);
        logic signed [8:0] diff;
        logic [8:0] mag;
        logic [8:0] amt;
        diff = $signed({1'b0, target}) - $signed({1'b0, duty});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        amt  = (mag > {1'b0, step}) ? {1'b0, step} : mag;
        ramp_next = diff[8] ? 8'({1'b0, duty} - amt) : 8'({1'b0, duty} + amt);
    endfunction

endpackage

// File: rtl/pwm_ctrl_if.sv
// pwm_ctrl_if: decoder <-> PWM channel bundle.
// master (decoder): drives pwm_enable, pwm_update, pwm_target; reads pwm_done, pwm_duty, pwm_signal.
// slave (pwm_ctrl): the reverse.
interface pwm_ctrl_if;

    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_target;
    logic       pwm_done;
    logic [7:0] pwm_duty;
    logic       pwm_signal;

    modport master (
        output pwm_enable, pwm_update, pwm_target,
        input  pwm_done, pwm_duty, pwm_signal
    );

    modport slave (
        input  pwm_enable, pwm_update, pwm_target,
        output pwm_done, pwm_duty, pwm_signal
    );

endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler plus 0..254 period counter for one PWM channel.
// Ports: fpga_clock/reset_n (sync, active-low), clear_i (zero both counters),
//        tick_o (prescaler wrap), boundary_o (tick with counter at 254), count_o (period counter).
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       fpga_clock,
    input  logic       reset_n,
    input  logic       clear_i,
    output logic       tick_o,
    output logic       boundary_o,
    output logic [7:0] count_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    count_q, count_d;

    always_comb begin
        tick_o     = presc_q == PS_LAST;
        boundary_o = tick_o && count_q == PERIOD_LAST;
        presc_d    = (clear_i || tick_o) ? '0 : presc_q + PW'(1);
        count_d    = (clear_i || boundary_o) ? 8'd0 : tick_o ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge fpga_clock) begin
        if (!reset_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: one PWM channel that ramps its applied duty toward a latched target.
// Ports: fpga_clock, reset_n (sync, active-low); bus (pwm_ctrl_if.slave):
//        pwm_enable/pwm_update/pwm_target in, pwm_done/pwm_duty/pwm_signal out.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic       fpga_clock,
    input  logic       reset_n,
    pwm_ctrl_if.slave  bus
);

    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    logic       tick, boundary;
    logic [7:0] count;

    pwm_state_e state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [7:0] duty_q, duty_d;
    logic       sig_q, sig_d;

    pwm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .fpga_clock (fpga_clock),
        .reset_n    (reset_n),
        .clear_i    (!bus.pwm_enable),
        .tick_o     (tick),
        .boundary_o (boundary),
        .count_o    (count)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        duty_d   = duty_q;
        // The counter tops out at 254, so full scale is held high explicitly.
        sig_d    = duty_q == PWM_MAX || count < duty_q;
        if (!bus.pwm_enable) begin
            state_d = IDLE;
            duty_d  = 8'd0;
            sig_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.pwm_update) begin
                    target_d = bus.pwm_target;
                    state_d  = RAMP;
                end
                // Duty only moves on the period wrap, so no pulse is ever cut short.
                RAMP: if (tick && boundary) begin
                    if (duty_q == target_q) state_d = DONE;
                    else duty_d = ramp_next(duty_q, target_q, STEP);
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fpga_clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            target_q <= 8'd0;
            duty_q   <= 8'd0;
            sig_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            sig_q    <= sig_d;
        end
    end

    assign bus.pwm_done   = state_q == DONE;
    assign bus.pwm_duty   = duty_q;
    assign bus.pwm_signal = sig_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed plus random requests against a step-list model of the ramp.
module tb_pwm_ctrl;

    localparam int STEP   = 8;
    localparam int PERIOD = 255;

    logic fpga_clock = 1'b0;
    logic reset_n    = 1'b0;
    int   checks     = 0;
    int   errors     = 0;
    int   mdl_duty   = 0;

    pwm_ctrl_if bus();

    pwm_ctrl #(.CLK_DIV(1), .RAMP_STEP(STEP)) dut (
        .fpga_clock (fpga_clock),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 fpga_clock = ~fpga_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Issue one request, follow it to done, and compare the sequence of applied
    // duties, per-period high time and done timing with the model. alt >= 0
    // rewrites pwm_target after the first step, which the channel must ignore.
    task automatic request(input logic [7:0] t, input int alt);
        int  exp_q[$];
        int  obs_q[$];
        int  d, gap, highs, since, prev, n, k, extra;
        bit  done;
        d = mdl_duty;
        while (d != int'(t)) begin
            gap = int'(t) - d;
            d += (gap > STEP) ? STEP : (gap < -STEP) ? -STEP : gap;
            exp_q.push_back(d);
        end
        k = exp_q.size();
        bus.pwm_target = t;
        bus.pwm_update = 1'b1;
        highs = 0; since = 0; prev = mdl_duty; n = 0; done = 1'b0;
        while (!done && n < PERIOD * (k + 2)) begin
            @(negedge fpga_clock);
            n++;
            highs += int'(bus.pwm_signal);
            since++;
            if (int'(bus.pwm_duty) != prev || bus.pwm_done) begin
                if (obs_q.size() > 0) begin
                    chk("period_len", since, PERIOD);
                    chk("high_time", highs, prev);
                end
                if (bus.pwm_done) done = 1'b1;
                else begin
                    obs_q.push_back(int'(bus.pwm_duty));
                    prev = int'(bus.pwm_duty);
                    if (alt >= 0 && obs_q.size() == 1) bus.pwm_target = 8'(alt);
                end
                highs = 0;
                since = 0;
            end
        end
        chk("done_seen", done, 1);
        chk("done_latency", (n >= PERIOD * k + 2) && (n <= PERIOD * (k + 1) + 1), 1);
        chk("step_count", obs_q.size(), k);
        foreach (exp_q[i]) chk("step_val", (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
        chk("final_duty", bus.pwm_duty, t);
        bus.pwm_update = 1'b0;
        @(negedge fpga_clock);
        chk("done_width", bus.pwm_done, 0);
        extra = 0;
        repeat (PERIOD + 2) begin
            @(negedge fpga_clock);
            extra += int'(bus.pwm_done) + ((bus.pwm_duty != t) ? 1 : 0);
        end
        chk("no_redone", extra, 0);
        mdl_duty = int'(t);
    endtask

    initial begin
        int n;
        int acc;
        bus.pwm_enable = 1'b1;
        bus.pwm_update = 1'b1;
        bus.pwm_target = 8'h80;
        reset_n = 1'b0;
        repeat (5) begin
            @(negedge fpga_clock);
            chk("rst_signal", bus.pwm_signal, 0);
            chk("rst_duty", bus.pwm_duty, 0);
            chk("rst_done", bus.pwm_done, 0);
        end
        bus.pwm_update = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge fpga_clock);

        request(8'd20, -1);
        request(8'd255, -1);
        request(8'd0, -1);

        bus.pwm_target = 8'd200;
        bus.pwm_update = 1'b1;
        n = 0;
        while (bus.pwm_duty != 8'd40 && n < PERIOD * 7) begin
            @(negedge fpga_clock);
            n++;
        end
        chk("reach_40", bus.pwm_duty, 40);
        bus.pwm_enable = 1'b0;
        @(negedge fpga_clock);
        chk("dis_duty", bus.pwm_duty, 0);
        chk("dis_signal", bus.pwm_signal, 0);
        chk("dis_done", bus.pwm_done, 0);
        acc = 0;
        repeat (20) begin
            @(negedge fpga_clock);
            acc += int'(bus.pwm_signal) + int'(bus.pwm_done) + int'(bus.pwm_duty);
        end
        chk("dis_quiet", acc, 0);
        bus.pwm_enable = 1'b1;
        mdl_duty = 0;
        request(8'd200, 5);

        request(8'd100, -1);
        request(8'd100, -1);

        bus.pwm_target = 8'd60;
        bus.pwm_update = 1'b1;
        n = 0;
        while (bus.pwm_duty == 8'd100 && n < PERIOD * 2) begin
            @(negedge fpga_clock);
            n++;
        end
        chk("mid_step", bus.pwm_duty, 92);
        reset_n = 1'b0;
        bus.pwm_update = 1'b0;
        @(negedge fpga_clock);
        chk("mid_rst_duty", bus.pwm_duty, 0);
        chk("mid_rst_signal", bus.pwm_signal, 0);
        chk("mid_rst_done", bus.pwm_done, 0);
        reset_n = 1'b1;
        acc = 0;
        repeat (PERIOD + 2) begin
            @(negedge fpga_clock);
            acc += int'(bus.pwm_signal) + int'(bus.pwm_done) + int'(bus.pwm_duty);
        end
        chk("post_rst_quiet", acc, 0);
        mdl_duty = 0;

        repeat (2) request(8'($urandom_range(0, 255)), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
